// File: rtl/parallel_serial_tx_if.sv
// Byte-in / bit-out bus of parallel_serial_tx.
// The producer side (master) drives DATA_IN/VALID_IN and observes the handshake
// and the serial line; the transmitter (slave) drives READY_OUT, DATA_OUT, ACTIVE.
interface parallel_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA_IN;
    logic             VALID_IN;
    logic             READY_OUT;
    logic             DATA_OUT;
    logic             ACTIVE;

    modport master (
        output DATA_IN,
        output VALID_IN,
        input  READY_OUT,
        input  DATA_OUT,
        input  ACTIVE
    );

    modport slave (
        input  DATA_IN,
        input  VALID_IN,
        output READY_OUT,
        output DATA_OUT,
        output ACTIVE
    );
endinterface

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: turns a valid/ready byte stream into a 1-bit-per-clock
// serial line, MSB first. The idle filler is the COM alignment symbol; after
// reset MIN_COM complete COM symbols are sent before any data is accepted.
// A one-entry holding buffer decouples the producer from the line.
// Optional feature macro: PS_STATS_EN adds TX_COUNT / COM_COUNT outputs that
// count data and COM symbols loaded onto the line (16-bit, wrapping).
// WIDTH must be at least 2.
module parallel_serial_tx #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] COM_SYM = 8'hBC,
    parameter int               MIN_COM = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    parallel_serial_tx_if.slave  bus
`ifdef PS_STATS_EN
    ,
    output logic [15:0]          TX_COUNT,
    output logic [15:0]          COM_COUNT
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int COM_W = $clog2(MIN_COM + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [COM_W-1:0] COM_LAST = COM_W'(MIN_COM - 1);

    typedef enum logic [0:0] {
        ST_SYNC    = 1'b0,
        ST_DATA_OK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;   // position of the bit on DATA_OUT
    logic               started_q, started_d;   // line has emitted its first bit
    logic [WIDTH-1:0]   sym_q, sym_d;           // remaining bits of current symbol
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [COM_W-1:0]   com_cnt_q, com_cnt_d;
    logic               data_out_q, data_out_d;
    logic               active_q, active_d;

    logic               boundary_s;
    logic               load_data_s;
    logic [WIDTH-1:0]   next_sym_s;
    logic               com_done_s;
    logic               ready_s;
    logic               write_s;

    // The very first edge after reset starts a symbol just like a wrap does,
    // so the line begins with the MSB of a COM with no dead bit.
    assign boundary_s  = !started_q || (bit_cnt_q == LAST_BIT);
    assign load_data_s = boundary_s && (state_q == ST_DATA_OK) && buf_full_q;
    assign next_sym_s  = load_data_s ? buf_q : COM_SYM;
    // In SYNC every symbol is a COM; it is complete when its LSB goes out.
    assign com_done_s  = (state_q == ST_SYNC) && !boundary_s && (bit_cnt_q == PRE_LAST);
    assign write_s     = bus.VALID_IN && ready_s;

    // State register: SYNC preamble, then DATA_OK until the next reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SYNC once the last preamble COM has been fully sent
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (com_done_s && (com_cnt_q == COM_LAST)) begin
                    state_d = ST_DATA_OK;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_DATA_OK: state_d = ST_DATA_OK;
            default:    state_d = ST_SYNC;
        endcase
    end

    // Handshake output: open when the buffer is empty or drains on this edge
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            ST_SYNC:    ready_s = 1'b0;
            ST_DATA_OK: ready_s = !buf_full_q || (bit_cnt_q == LAST_BIT);
            default:    ready_s = 1'b0;
        endcase
    end

    // Datapath next state: bit sequencing, symbol selection, buffer, preamble count
    always_comb begin
        started_d  = 1'b1;
        bit_cnt_d  = bit_cnt_q;
        sym_d      = sym_q;
        data_out_d = data_out_q;
        active_d   = active_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        com_cnt_d  = com_cnt_q;

        if (boundary_s) begin
            bit_cnt_d  = {CNT_W{1'b0}};
            data_out_d = next_sym_s[WIDTH-1];
            sym_d      = {next_sym_s[WIDTH-2:0], 1'b0};
            active_d   = load_data_s;
        end else begin
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            data_out_d = sym_q[WIDTH-1];
            sym_d      = {sym_q[WIDTH-2:0], 1'b0};
            active_d   = active_q;
        end

        if (com_done_s) begin
            com_cnt_d = com_cnt_q + COM_W'(1);
        end else begin
            com_cnt_d = com_cnt_q;
        end

        // A write on a draining edge refills the buffer: old byte to the line,
        // new byte held for the following symbol.
        if (write_s) begin
            buf_d      = bus.DATA_IN;
            buf_full_d = 1'b1;
        end else if (load_data_s) begin
            buf_d      = buf_q;
            buf_full_d = 1'b0;
        end else begin
            buf_d      = buf_q;
            buf_full_d = buf_full_q;
        end
    end

    // Datapath registers; reset drops any partial symbol and buffered byte
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            started_q  <= 1'b0;
            bit_cnt_q  <= {CNT_W{1'b0}};
            sym_q      <= COM_SYM;
            data_out_q <= 1'b0;
            active_q   <= 1'b0;
            buf_q      <= {WIDTH{1'b0}};
            buf_full_q <= 1'b0;
            com_cnt_q  <= {COM_W{1'b0}};
        end else begin
            started_q  <= started_d;
            bit_cnt_q  <= bit_cnt_d;
            sym_q      <= sym_d;
            data_out_q <= data_out_d;
            active_q   <= active_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            com_cnt_q  <= com_cnt_d;
        end
    end

    assign bus.READY_OUT = ready_s;
    assign bus.DATA_OUT  = data_out_q;
    assign bus.ACTIVE    = active_q;

`ifdef PS_STATS_EN
    logic [15:0] tx_count_q, tx_count_d;
    logic [15:0] com_count_q, com_count_d;

    // Statistics next state: one count per symbol loaded, by symbol kind
    always_comb begin
        tx_count_d  = tx_count_q;
        com_count_d = com_count_q;
        if (load_data_s) begin
            tx_count_d = tx_count_q + 16'd1;
        end else if (boundary_s) begin
            com_count_d = com_count_q + 16'd1;
        end else begin
            tx_count_d  = tx_count_q;
            com_count_d = com_count_q;
        end
    end

    // Statistics registers, wrapping naturally at 16 bits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_count_q  <= 16'd0;
            com_count_q <= 16'd0;
        end else begin
            tx_count_q  <= tx_count_d;
            com_count_q <= com_count_d;
        end
    end

    assign TX_COUNT  = tx_count_q;
    assign COM_COUNT = com_count_q;
`endif

endmodule
